// File: rtl/fifo_param.sv
// Parametrised synchronous first-word-fall-through FIFO.
// Producer pushes with pin; consumer pops by holding its stall (sin) low.
// All DEPTH entries are usable: pointers carry an extra wrap bit so that
// full and empty can be told apart without sacrificing a slot.
// Adds occupancy count, almost-full/almost-empty thresholds and sticky
// overflow/underflow flags cleared by clr_err.
module fifo_param #(
    parameter int unsigned WIDTH    = 9,
    parameter int unsigned DEPTH    = 32,
    localparam int unsigned AW      = $clog2(DEPTH),
    parameter int unsigned AF_LEVEL = DEPTH - 4,
    parameter int unsigned AE_LEVEL = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pin,
    input  logic             sin,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic             pout,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    // Thresholds and increment sized to the count/pointer width.
    localparam logic [AW:0] AfThresh = (AW + 1)'(AF_LEVEL);
    localparam logic [AW:0] AeThresh = (AW + 1)'(AE_LEVEL);
    localparam logic [AW:0] One      = (AW + 1)'(1);

    // Reject illegal configurations at elaboration time.
    if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 4)) begin : g_bad_depth
        $error("fifo_param: DEPTH must be a power of two and at least 4");
    end
    if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
        $error("fifo_param: AE_LEVEL must be below AF_LEVEL");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;

    logic        empty;
    logic        full_int;
    logic        rd_acc;
    logic        wr_acc;
    logic        wr_en;
    logic [AW-1:0] wr_addr;

    // Status derived from the registered pointers; handshake accepts.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full_int = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
        rd_acc   = !sin && !empty;
        // A push into a full FIFO only succeeds when a pop frees a slot.
        wr_acc   = pin && (!full_int || rd_acc);
        wr_en    = wr_acc && !reset;
        wr_addr  = wr_ptr_q[AW-1:0];
    end

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + One;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + One;
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + One;
            2'b01:   count_d = count_q - One;
            default: count_d = count_q;
        endcase

        // Clear first so that a simultaneous set wins.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (pin && !wr_acc) begin
            overflow_d = 1'b1;
        end
        if (!sin && empty) begin
            underflow_d = 1'b1;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents are not reset, stale words are unreachable.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= din;
        end
    end

    // Outputs: head of queue falls through combinationally from storage.
    always_comb begin
        pout         = !empty;
        dout         = mem_q[rd_ptr_q[AW-1:0]];
        full         = full_int;
        count        = count_q;
        almost_full  = (count_q >= AfThresh);
        almost_empty = (count_q <= AeThresh);
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed scenarios plus a randomized
// stream, all compared against a queue-based reference model.
module tb_fifo_param;

    localparam int unsigned WIDTH = 9;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             pin = 1'b0;
    logic             sin = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic             clr_err = 1'b0;
    logic             pout;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    int errors = 0;
    int checks = 0;

    // Reference model: plain queue of words plus sticky flags.
    logic [WIDTH-1:0] mq[$];
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    fifo_param #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pin         (pin),
        .sin         (sin),
        .din         (din),
        .clr_err     (clr_err),
        .pout        (pout),
        .dout        (dout),
        .full        (full),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clock = ~clock;

    // Advance one clock edge, updating the model from the applied inputs.
    task automatic step();
        int n;
        bit rd;
        bit wr;
        n  = mq.size();
        rd = !sin && (n > 0);
        wr = pin && ((n < DEPTH) || rd);
        @(posedge clock);
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (rd) void'(mq.pop_front());
            if (wr) mq.push_back(din);
            m_ovf = (pin && !wr) ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
            m_unf = (!sin && n == 0) ? 1'b1 : (clr_err ? 1'b0 : m_unf);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        checks++; if (count !== '0) begin errors++;
            $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (pout !== 1'b0) begin errors++;
            $display("FAIL reset_pout: got %b expected 0", pout); end
        checks++; if (almost_empty !== 1'b1) begin errors++;
            $display("FAIL reset_almost_empty: got %b expected 1", almost_empty); end
        checks++; if (full !== 1'b0) begin errors++;
            $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++;
            $display("FAIL reset_almost_full: got %b expected 0", almost_full); end
        checks++; if (overflow !== 1'b0) begin errors++;
            $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (underflow !== 1'b0) begin errors++;
            $display("FAIL reset_underflow: got %b expected 0", underflow); end
    endtask

    task automatic test_fill_overflow();
        sin = 1'b1;
        pin = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            din = WIDTH'(i);
            step();
            checks++; if (count !== (AW + 1)'(mq.size())) begin errors++;
                $display("FAIL fill_count: got %0d expected %0d", count, mq.size()); end
            if (i == 27) begin
                checks++; if (almost_full !== 1'b0) begin errors++;
                    $display("FAIL fill_af27: got %b expected 0", almost_full); end
            end
            if (i == 28) begin
                checks++; if (almost_full !== 1'b1) begin errors++;
                    $display("FAIL fill_af28: got %b expected 1", almost_full); end
            end
            if (i == 31) begin
                checks++; if (full !== 1'b0) begin errors++;
                    $display("FAIL fill_full31: got %b expected 0", full); end
            end
        end
        checks++; if (full !== 1'b1) begin errors++;
            $display("FAIL fill_full: got %b expected 1", full); end
        checks++; if (count !== 6'd32) begin errors++;
            $display("FAIL fill_count32: got %0d expected 32", count); end
        din = 9'h033;
        step();
        pin = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++;
            $display("FAIL ovf_set: got %b expected 1", overflow); end
        checks++; if (count !== 6'd32) begin errors++;
            $display("FAIL ovf_count: got %0d expected 32", count); end
        checks++; if (dout !== 9'h001) begin errors++;
            $display("FAIL ovf_dout: got %h expected 001", dout); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++;
            $display("FAIL ovf_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [WIDTH-1:0] last;
        last = '0;
        pin = 1'b1;
        sin = 1'b0;
        din = 9'h1AA;
        step();
        pin = 1'b0;
        checks++; if (count !== 6'd32) begin errors++;
            $display("FAIL fpp_count: got %0d expected 32", count); end
        checks++; if (full !== 1'b1) begin errors++;
            $display("FAIL fpp_full: got %b expected 1", full); end
        checks++; if (dout !== 9'h002) begin errors++;
            $display("FAIL fpp_dout: got %h expected 002", dout); end
        checks++; if (overflow !== 1'b0) begin errors++;
            $display("FAIL fpp_overflow: got %b expected 0", overflow); end
        for (int i = 0; i < 32; i++) begin
            checks++; if (dout !== mq[0]) begin errors++;
                $display("FAIL drain_dout[%0d]: got %h expected %h", i, dout, mq[0]); end
            last = dout;
            step();
        end
        sin = 1'b1;
        checks++; if (last !== 9'h1AA) begin errors++;
            $display("FAIL drain_last: got %h expected 1aa", last); end
        checks++; if (pout !== 1'b0) begin errors++;
            $display("FAIL drain_pout: got %b expected 0", pout); end
    endtask

    task automatic test_empty_push_pop();
        pin = 1'b1;
        sin = 1'b0;
        din = 9'h155;
        step();
        pin = 1'b0;
        sin = 1'b1;
        checks++; if (underflow !== 1'b1) begin errors++;
            $display("FAIL epp_underflow: got %b expected 1", underflow); end
        checks++; if (pout !== 1'b1) begin errors++;
            $display("FAIL epp_pout: got %b expected 1", pout); end
        checks++; if (dout !== 9'h155) begin errors++;
            $display("FAIL epp_dout: got %h expected 155", dout); end
        checks++; if (count !== 6'd1) begin errors++;
            $display("FAIL epp_count: got %0d expected 1", count); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++; if (underflow !== 1'b0) begin errors++;
            $display("FAIL epp_clear: got %b expected 0", underflow); end
        sin = 1'b0;
        step();
        sin = 1'b1;
        checks++; if (count !== 6'd0) begin errors++;
            $display("FAIL epp_pop_count: got %0d expected 0", count); end
    endtask

    task automatic test_stream();
        int pushed;
        int cyc;
        pushed = 0;
        cyc = 0;
        while ((pushed < 100 || mq.size() > 0) && cyc < 3000) begin
            pin = (pushed < 100) && (mq.size() < DEPTH);
            din = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            sin = 1'($urandom_range(0, 1));
            if (pin) pushed++;
            step();
            cyc++;
            checks++; if (count !== (AW + 1)'(mq.size())) begin errors++;
                $display("FAIL str_count@%0d: got %0d expected %0d", cyc, count, mq.size()); end
            checks++; if (pout !== (mq.size() > 0)) begin errors++;
                $display("FAIL str_pout@%0d: got %b expected %b", cyc, pout, mq.size() > 0); end
            if (mq.size() > 0) begin
                checks++; if (dout !== mq[0]) begin errors++;
                    $display("FAIL str_dout@%0d: got %h expected %h", cyc, dout, mq[0]); end
            end
            checks++; if (full !== (mq.size() == DEPTH)) begin errors++;
                $display("FAIL str_full@%0d: got %b", cyc, full); end
            checks++; if (almost_full !== (mq.size() >= DEPTH - 4)) begin errors++;
                $display("FAIL str_af@%0d: got %b size %0d", cyc, almost_full, mq.size()); end
            checks++; if (almost_empty !== (mq.size() <= 4)) begin errors++;
                $display("FAIL str_ae@%0d: got %b size %0d", cyc, almost_empty, mq.size()); end
            checks++; if (overflow !== m_ovf) begin errors++;
                $display("FAIL str_ovf@%0d: got %b expected %b", cyc, overflow, m_ovf); end
            checks++; if (underflow !== m_unf) begin errors++;
                $display("FAIL str_unf@%0d: got %b expected %b", cyc, underflow, m_unf); end
        end
        pin = 1'b0;
        sin = 1'b1;
        checks++; if (cyc >= 3000) begin errors++;
            $display("FAIL str_timeout: got %0d cycles expected under 3000", cyc); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    task automatic test_reset_mid();
        sin = 1'b1;
        pin = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            step();
        end
        checks++; if (count !== 6'd10) begin errors++;
            $display("FAIL rm_fill: got %0d expected 10", count); end
        reset = 1'b1;
        din = 9'h1FF;
        step();
        reset = 1'b0;
        pin = 1'b0;
        checks++; if (count !== 6'd0) begin errors++;
            $display("FAIL rm_count: got %0d expected 0", count); end
        checks++; if (pout !== 1'b0) begin errors++;
            $display("FAIL rm_pout: got %b expected 0", pout); end
        pin = 1'b1;
        din = 9'h0F0;
        step();
        pin = 1'b0;
        checks++; if (pout !== 1'b1) begin errors++;
            $display("FAIL rm_push_pout: got %b expected 1", pout); end
        checks++; if (dout !== 9'h0F0) begin errors++;
            $display("FAIL rm_push_dout: got %h expected 0f0", dout); end
        checks++; if (count !== 6'd1) begin errors++;
            $display("FAIL rm_push_count: got %0d expected 1", count); end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_stream();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
